// File: rtl/speaker_pcm.sv
// Turns the $C030 speaker flip-flop level into unsigned PCM samples by measuring
// how long the level is high in each audio sample period.
module speaker_pcm #(
    parameter int unsigned CLOCK_SPEED_HZ  = 54_000_000,
    parameter int unsigned AUDIO_RATE      = 44100,
    parameter int unsigned AMPLITUDE       = 16'h2000,
    parameter int unsigned TIMEOUT_SAMPLES = 255,
    parameter int unsigned ENABLE          = 1
) (
    input  logic        clk_pixel_w,
    input  logic        system_reset_n_w,
    input  logic        speaker_toggle_i,
    output logic        sample_strobe_o,
    output logic [15:0] sample_o,
    output logic        active_o
);

    localparam int unsigned DIV        = (CLOCK_SPEED_HZ / 2) / AUDIO_RATE;
    localparam int unsigned AMP_STEP   = AMPLITUDE / DIV;
    localparam int unsigned DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned HIGH_MIN_W = 10;
    localparam int unsigned HIGH_W     = ($clog2(DIV + 1) > HIGH_MIN_W) ? $clog2(DIV + 1) : HIGH_MIN_W;
    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned PROD_W     = HIGH_W + SAMPLE_W;
    localparam int unsigned IDLE_W     = 8;

    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDLE_W-1:0]   IDLE_LOAD = IDLE_W'(TIMEOUT_SAMPLES);
    localparam logic [PROD_W-1:0]   AMP_WIDE  = PROD_W'(AMPLITUDE);
    localparam logic [PROD_W-1:0]   STEP_WIDE = PROD_W'(AMP_STEP);

    logic                sync1_q;
    logic                sync2_q;
    logic                hist_q;
    logic                level_q;
    logic [DIV_W-1:0]    div_q;
    logic [HIGH_W-1:0]   high_q;
    logic [IDLE_W-1:0]   idle_q;

    logic                edge_c;
    logic                tick_c;
    logic                gated_c;
    logic [HIGH_W-1:0]   high_total_c;
    logic [PROD_W-1:0]   prod_c;
    logic [SAMPLE_W-1:0] sample_c;
    logic                level_d;
    logic [DIV_W-1:0]    div_d;
    logic [HIGH_W-1:0]   high_d;
    logic [IDLE_W-1:0]   idle_d;
    logic [SAMPLE_W-1:0] sample_d;

    // Next-state: the tick cycle's own high time closes the current period, and the
    // gate uses pre-edge level/idle so a new level only counts from the next cycle.
    always_comb begin
        edge_c       = sync2_q ^ hist_q;
        tick_c       = (div_q == DIV_LAST);
        gated_c      = level_q & (idle_q != '0);
        high_total_c = high_q + HIGH_W'(gated_c);
        prod_c       = PROD_W'(high_total_c) * STEP_WIDE;
        sample_c     = (prod_c > AMP_WIDE) ? SAMPLE_W'(AMPLITUDE) : prod_c[SAMPLE_W-1:0];

        level_d  = level_q ^ edge_c;
        div_d    = tick_c ? '0 : div_q + DIV_W'(1);
        high_d   = tick_c ? '0 : high_total_c;
        idle_d   = idle_q;
        sample_d = sample_o;

        if (edge_c) begin
            idle_d = IDLE_LOAD;
        end else if (tick_c && (idle_q != '0)) begin
            idle_d = idle_q - IDLE_W'(1);
        end

        if (tick_c) begin
            sample_d = (ENABLE != 0) ? sample_c : '0;
        end
    end

    always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
        if (!system_reset_n_w) begin
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
            hist_q          <= 1'b0;
            level_q         <= 1'b0;
            div_q           <= '0;
            high_q          <= '0;
            idle_q          <= '0;
            sample_o        <= '0;
            sample_strobe_o <= 1'b0;
            active_o        <= 1'b0;
        end else begin
            sync1_q         <= speaker_toggle_i;
            sync2_q         <= sync1_q;
            hist_q          <= sync2_q;
            level_q         <= level_d;
            div_q           <= div_d;
            high_q          <= high_d;
            idle_q          <= idle_d;
            sample_o        <= sample_d;
            sample_strobe_o <= tick_c;
            active_o        <= (idle_d != '0);
        end
    end

endmodule

// File: tb/tb_speaker_pcm.sv
// Bench for speaker_pcm: scheduled speaker toggles, per-period expected samples
// from a table queued as a scoreboard, plus a mid-period reset sequence.
module tb_speaker_pcm;

    localparam int unsigned DIV  = 612;
    localparam int unsigned TMO  = 6;
    localparam int          FULL = 7956;
    localparam int          HALF = 3978;

    logic        clk_pixel_w      = 1'b0;
    logic        system_reset_n_w = 1'b0;
    logic        speaker_toggle_i = 1'b0;
    logic        sample_strobe_o;
    logic [15:0] sample_o;
    logic        active_o;
    logic        strobe_off;
    logic [15:0] sample_off;
    logic        active_off;

    speaker_pcm #(.TIMEOUT_SAMPLES(TMO), .ENABLE(1)) dut (
        .clk_pixel_w      (clk_pixel_w),
        .system_reset_n_w (system_reset_n_w),
        .speaker_toggle_i (speaker_toggle_i),
        .sample_strobe_o  (sample_strobe_o),
        .sample_o         (sample_o),
        .active_o         (active_o)
    );

    speaker_pcm #(.TIMEOUT_SAMPLES(TMO), .ENABLE(0)) dut_off (
        .clk_pixel_w      (clk_pixel_w),
        .system_reset_n_w (system_reset_n_w),
        .speaker_toggle_i (speaker_toggle_i),
        .sample_strobe_o  (strobe_off),
        .sample_o         (sample_off),
        .active_o         (active_off)
    );

    always #5 clk_pixel_w = ~clk_pixel_w;

    // Cycle index since reset release: interval n follows the n-th posedge.
    int cyc;
    always @(posedge clk_pixel_w or negedge system_reset_n_w) begin
        if (!system_reset_n_w) cyc <= 0;
        else                   cyc <= cyc + 1;
    end

    typedef struct packed {
        logic [15:0] sample;
        logic        active;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input int idx, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s[%0d]: got %0d, required %0d", name, idx, act, req);
        end
    endtask

    function automatic void add(input int n, input int s, input bit a);
        for (int i = 0; i < n; i++) exp_q.push_back('{16'(s), a});
    endfunction

    // Scoreboard monitor: every strobe pops one expected period result.
    int          sidx;
    logic [15:0] held;
    bit          changed;
    always @(negedge clk_pixel_w) begin
        exp_t e;
        if (!system_reset_n_w) begin
            sidx    = 0;
            held    = '0;
            changed = 1'b0;
        end else begin
            if (!sample_strobe_o && (sample_o != held)) changed = 1'b1;
            if (strobe_off != sample_strobe_o) check("strobe_off_cadence", cyc, int'(strobe_off), int'(sample_strobe_o));
            if (sample_strobe_o) begin
                check("strobe_cycle", sidx, cyc, int'(DIV) * (sidx + 1));
                check("hold_between_strobes", sidx, int'(changed), 0);
                check("off_sample", sidx, int'(sample_off), 0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_strobe[%0d]: got strobe at cycle %0d, required none", sidx, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("sample", sidx, int'(sample_o), int'(e.sample));
                    check("active", sidx, int'(active_o), int'(e.active));
                    check("off_active", sidx, int'(active_off), int'(e.active));
                end
                held    = sample_o;
                changed = 1'b0;
                sidx++;
            end
        end
    end

    task automatic wait_cyc(input int m);
        while (cyc < m) @(negedge clk_pixel_w);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1);
    end

    initial begin
        int tlist[$];

        // Expected result per sample period (sample, active).
        add(1, 0, 0);       // p0 idle
        add(1, 0, 1);       // p1 edge lands on tick, level was 0
        add(5, FULL, 1);    // p2..p6 level held high
        add(1, FULL, 0);    // p7 last counted period, idle reaches 0
        add(1, 0, 0);       // p8 timed out
        add(2, 0, 1);       // p9 fall mid-period, p10 rise on tick
        add(5, FULL, 1);    // p11..p15
        add(1, FULL, 0);    // p16 reload was full timeout, not one less
        add(1, 0, 1);       // p17 fall on tick while gated off
        add(4, HALF, 1);    // p18..p21 half-period toggling
        add(6, 0, 1);       // p22..p27 low, rise on p27 tick
        add(1, FULL, 1);    // p28

        tlist = {1221, 5608, 6729};
        for (int j = 0; j < 9; j++) tlist.push_back(11013 + 306 * j);
        tlist.push_back(17133);

        repeat (3) @(negedge clk_pixel_w);
        check("reset_sample", 0, int'(sample_o), 0);
        check("reset_active", 0, int'(active_o), 0);
        check("reset_strobe", 0, int'(sample_strobe_o), 0);
        system_reset_n_w = 1'b1;

        foreach (tlist[k]) begin
            wait_cyc(tlist[k]);
            speaker_toggle_i = ~speaker_toggle_i;
        end

        // Reset in the middle of period 29 with the level high.
        wait_cyc(int'(DIV) * 29 + 300);
        check("pre_reset_sample", 0, int'(sample_o), FULL);
        check("pre_reset_active", 0, int'(active_o), 1);
        check("drained_before_reset", 0, exp_q.size(), 0);
        #1;
        system_reset_n_w = 1'b0;
        speaker_toggle_i = 1'b0;
        #1;
        check("mid_reset_sample", 0, int'(sample_o), 0);
        check("mid_reset_active", 0, int'(active_o), 0);
        check("mid_reset_strobe", 0, int'(sample_strobe_o), 0);
        check("mid_reset_off_active", 0, int'(active_off), 0);
        repeat (4) @(negedge clk_pixel_w);
        system_reset_n_w = 1'b1;

        add(1, 0, 1);       // p0 rise on tick, partial pre-reset period discarded
        add(2, FULL, 1);    // p1..p2 level restarts at 1
        wait_cyc(609);
        speaker_toggle_i = 1'b1;

        while ((exp_q.size() > 0) && (cyc < int'(DIV) * 4)) @(negedge clk_pixel_w);
        check("post_reset_drain", 0, exp_q.size(), 0);
        repeat (10) @(negedge clk_pixel_w);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/speaker_pcm.md
SPEAKER_PCM -- requirements
Module: speaker_pcm

Interface
REQ-001 SHALL have parameter CLOCK_SPEED_HZ, default 54_000_000: logic clock in Hz; pixel clock is CLOCK_SPEED_HZ/2.
REQ-002 SHALL have parameter AUDIO_RATE, default 44100: output sample rate in Hz.
REQ-003 SHALL have parameter AMPLITUDE, default 16'h2000: full-scale sample value for a 100% high period.
REQ-004 SHALL have parameter TIMEOUT_SAMPLES, default 255: number of sample periods after the last toggle before the level is forced low.
REQ-005 SHALL have parameter ENABLE, default 1: 0 forces sample_o to 0.
REQ-006 SHALL have port clk_pixel_w, input, 1 bit: clock.
REQ-007 SHALL have port system_reset_n_w, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port speaker_toggle_i, input, 1 bit: $C030 speaker flip-flop level, asynchronous, from the clk_logic domain.
REQ-009 SHALL have port sample_strobe_o, output, 1 bit: one-cycle pulse when sample_o updates.
REQ-010 SHALL have port sample_o, output, 16 bits: unsigned PCM sample for the HDMI audio mixer.
REQ-011 SHALL have port active_o, output, 1 bit: high while the timeout counter is nonzero.

Function
REQ-012 SHALL derive the constants DIV = (CLOCK_SPEED_HZ/2)/AUDIO_RATE (integer) and AMP_STEP = AMPLITUDE/DIV (integer); defaults give DIV=612 and AMP_STEP=13.
REQ-013 SHALL synchronise speaker_toggle_i through 2 flops plus 1 history flop; edge = sync XOR history; both rising and falling edges count.
REQ-014 SHALL maintain a divider counter running 0..DIV-1 and wrapping to 0; tick is asserted in the cycle where the counter equals DIV-1.
REQ-015 SHALL maintain an internal level register that toggles on each edge; the level is gated low whenever the idle counter is 0.
REQ-016 SHALL maintain a high counter (10-bit minimum) that increments on each cycle where the gated level is 1.
REQ-017 SHALL, on tick, load the high counter with 0 for the next period; the tick cycle's own contribution belongs to the closing period.
REQ-018 SHALL, in the cycle after tick, set sample_o = min(high_count × AMP_STEP, AMPLITUDE) and pulse sample_strobe_o for exactly 1 cycle; latency is 1 cycle from tick.
REQ-019 SHALL load the idle counter (8-bit) with TIMEOUT_SAMPLES on an edge, and otherwise decrement it on tick if nonzero; an edge wins over a simultaneous tick.
REQ-020 SHALL evaluate the contribution of a cycle where an edge and tick coincide using the pre-edge gated level; the new level counts from the next period.
REQ-021 SHALL hold sample_o at 0 when ENABLE=0; sample_strobe_o cadence is unaffected.
REQ-022 SHALL keep sample_strobe_o period exactly DIV cycles, with no drift and no dropped strobes.
REQ-023 SHALL hold sample_o stable between strobes.
REQ-024 SHALL ensure no arithmetic overflow: high_count max DIV, and the product is at least 16 bits wide before saturation.

Reset
REQ-025 SHALL, on assertion of system_reset_n_w, asynchronously clear to 0: synchroniser flops, level, divider, high counter, idle counter, sample_o, sample_strobe_o, active_o.
REQ-026 SHALL resume on release with the divider at 0; the first tick falls 611 cycles after the first active edge.
REQ-027 SHALL discard any partial period on reset mid-operation; it emits no strobe for that period.

Verification
REQ-028 Reset then idle: sample_o=0, active_o=0, sample_strobe_o pulses every 612 cycles, first pulse at cycle 612.
REQ-029 Single toggle 0->1 settled before a period start, then held: period samples = 7956 (612×13); active_o falls after 255 ticks; subsequent samples = 0.
REQ-030 Toggle every 306 cycles aligned to period start: every sample = 3978 (306×13); active_o stays 1.
REQ-031 Edge synchronised into the tick cycle with level previously 0: that sample = 0, next sample = 7956, idle counter = 255, not 254.
REQ-032 ENABLE=0 with a toggle every 306 cycles: sample_o = 0 always, strobes every 612 cycles, active_o follows toggles.
REQ-033 Reset asserted mid-period with level high: all outputs 0 immediately; after release, no strobe until cycle 612; next toggle starts level at 1.
